// File: rtl/video_timing.sv
// Video raster timing generator: pixel tick at half the clk rate, h/v counters,
// render strobes for the line buffers and registered VGA outputs.
module video_timing #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  output logic [8:0] display_line_idx,
  output logic       display_start_of_screen,
  output logic       display_start_of_line,
  output logic       display_next_pixel,
  input  logic [7:0] display_data,
  output logic [7:0] vga_pixel,
  output logic       vga_de,
  output logic       vga_hsync_n,
  output logic       vga_vsync_n
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_ACT_W   = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST_W  = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_SYNC_LO = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_HI = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_ACT_W   = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST_W  = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_SYNC_LO = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_HI = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic       phase_q, phase_d;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic [7:0] pixel_q, pixel_d;
  logic       de_q, de_d;
  logic       hsync_n_q, hsync_n_d;
  logic       vsync_n_q, vsync_n_d;

  logic tick;
  logic h_end;
  logic v_end;
  logic in_active;
  logic in_hsync;
  logic in_vsync;

  always_comb begin
    tick      = enable & phase_q;
    h_end     = (h_q == H_LAST_W);
    v_end     = (v_q == V_LAST_W);
    in_active = (h_q < H_ACT_W) && (v_q < V_ACT_W);
    in_hsync  = (h_q >= H_SYNC_LO) && (h_q < H_SYNC_HI);
    in_vsync  = (v_q >= V_SYNC_LO) && (v_q < V_SYNC_HI);

    phase_d   = phase_q;
    h_d       = h_q;
    v_d       = v_q;
    pixel_d   = pixel_q;
    de_d      = de_q;
    hsync_n_d = hsync_n_q;
    vsync_n_d = vsync_n_q;

    if (enable) begin
      phase_d = ~phase_q;
    end

    // All four VGA outputs load on the same tick from the same h/v, keeping them aligned.
    if (tick) begin
      h_d = h_end ? '0 : h_q + 10'd1;
      if (h_end) begin
        v_d = v_end ? '0 : v_q + 10'd1;
      end
      pixel_d   = in_active ? display_data : '0;
      de_d      = in_active;
      hsync_n_d = ~in_hsync;
      vsync_n_d = ~in_vsync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= 1'b0;
      h_q       <= '0;
      v_q       <= '0;
      pixel_q   <= '0;
      de_q      <= 1'b0;
      hsync_n_q <= 1'b1;
      vsync_n_q <= 1'b1;
    end else begin
      phase_q   <= phase_d;
      h_q       <= h_d;
      v_q       <= v_d;
      pixel_q   <= pixel_d;
      de_q      <= de_d;
      hsync_n_q <= hsync_n_d;
      vsync_n_q <= vsync_n_d;
    end
  end

  // Strobes are gated by tick, so reset (phase=0) and enable=0 both silence them.
  assign display_next_pixel      = tick & in_active;
  assign display_start_of_line   = tick & (h_q == H_ACT_W);
  assign display_start_of_screen = tick & (h_q == H_ACT_W) & v_end;
  assign display_line_idx        = v_end ? '0 : 9'(v_q + 10'd1);

  assign vga_pixel   = pixel_q;
  assign vga_de      = de_q;
  assign vga_hsync_n = hsync_n_q;
  assign vga_vsync_n = vsync_n_q;

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing with a reduced raster; reference derives position
// from the count of enabled clks since reset.
module tb_video_timing;

  localparam int unsigned HA = 16, HF = 4, HS = 6, HB = 5;
  localparam int unsigned VA = 10, VF = 2, VS = 2, VB = 3;
  localparam int unsigned HT = HA + HF + HS + HB;  // 31
  localparam int unsigned VT = VA + VF + VS + VB;  // 17

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] display_data = '0;
  logic [8:0] display_line_idx;
  logic       display_start_of_screen;
  logic       display_start_of_line;
  logic       display_next_pixel;
  logic [7:0] vga_pixel;
  logic       vga_de;
  logic       vga_hsync_n;
  logic       vga_vsync_n;

  video_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .enable                 (enable),
    .display_line_idx       (display_line_idx),
    .display_start_of_screen(display_start_of_screen),
    .display_start_of_line  (display_start_of_line),
    .display_next_pixel     (display_next_pixel),
    .display_data           (display_data),
    .vga_pixel              (vga_pixel),
    .vga_de                 (vga_de),
    .vga_hsync_n            (vga_hsync_n),
    .vga_vsync_n            (vga_vsync_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: ne = enabled clks since reset; tick index = ne/2, phase = ne%2.
  int unsigned ne;
  logic [7:0]  m_pix;
  logic        m_de, m_hs_n, m_vs_n;

  function automatic int unsigned f_h(input int unsigned n);
    return (n / 2) % HT;
  endfunction
  function automatic int unsigned f_v(input int unsigned n);
    return ((n / 2) / HT) % VT;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ne     <= 0;
      m_pix  <= '0;
      m_de   <= 1'b0;
      m_hs_n <= 1'b1;
      m_vs_n <= 1'b1;
    end else if (enable) begin
      if (ne % 2 == 1) begin
        m_de   <= (f_h(ne) < HA) && (f_v(ne) < VA);
        m_pix  <= ((f_h(ne) < HA) && (f_v(ne) < VA)) ? display_data : 8'd0;
        m_hs_n <= !((f_h(ne) >= HA + HF) && (f_h(ne) < HA + HF + HS));
        m_vs_n <= !((f_v(ne) >= VA + VF) && (f_v(ne) < VA + VF + VS));
      end
      ne <= ne + 1;
    end
  end

  // Per-cycle compare against the reference, plus literal pins at the frame corners.
  always @(negedge clk) begin
    int unsigned h, v;
    bit tk;
    h  = f_h(ne);
    v  = f_v(ne);
    tk = enable && rst_n && (ne % 2 == 1);
    check("next_pixel", display_next_pixel, int'(tk && h < HA && v < VA));
    check("start_of_line", display_start_of_line, int'(tk && h == HA));
    check("start_of_screen", display_start_of_screen, int'(tk && h == HA && v == VT - 1));
    check("line_idx", display_line_idx, (v == VT - 1) ? 0 : int'(v + 1));
    check("vga_pixel", vga_pixel, m_pix);
    check("vga_de", vga_de, m_de);
    check("vga_hsync_n", vga_hsync_n, m_hs_n);
    check("vga_vsync_n", vga_vsync_n, m_vs_n);
    if (tk && h == HA && v == VA - 1) begin
      check("lit_idx_last_visible", display_line_idx, 10);
      check("lit_sol_last_visible", display_start_of_line, 1);
    end
    if (tk && h == HA && v == VT - 1) begin
      check("lit_idx_wrap", display_line_idx, 0);
      check("lit_sos_wrap", display_start_of_screen, 1);
    end
  end

  // Data driver: h[7:0] pattern or random values.
  bit data_mode = 1'b1;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      display_data = data_mode ? 8'(f_h(ne)) : 8'($urandom);
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_pixel"}, vga_pixel, 0);
    check({tag, "_de"}, vga_de, 0);
    check({tag, "_hsync_n"}, vga_hsync_n, 1);
    check({tag, "_vsync_n"}, vga_vsync_n, 1);
    check({tag, "_np"}, display_next_pixel, 0);
    check({tag, "_sol"}, display_start_of_line, 0);
    check({tag, "_sos"}, display_start_of_screen, 0);
  endtask

  initial begin
    int n_sol, n_sos, n_np, n_hs, n_vs, n_de;
    bit found;

    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;

    // One full frame from release: 527 ticks in 1054 clks.
    n_sol = 0; n_sos = 0; n_np = 0; n_hs = 0; n_vs = 0; n_de = 0;
    repeat (2 * HT * VT) begin
      @(negedge clk);
      n_sol += int'(display_start_of_line);
      n_sos += int'(display_start_of_screen);
      n_np  += int'(display_next_pixel);
      n_hs  += int'(!vga_hsync_n);
      n_vs  += int'(!vga_vsync_n);
      n_de  += int'(vga_de);
    end
    check("frame_sol_count", n_sol, 17);
    check("frame_sos_count", n_sos, 1);
    check("frame_np_count", n_np, 160);
    check("frame_hsync_low_samples", n_hs, 204);
    check("frame_vsync_low_samples", n_vs, 124);
    check("frame_de_samples", n_de, 320);

    // Random enable and data.
    data_mode = 1'b0;
    repeat (3000) begin
      @(posedge clk);
      #1;
      enable = ($urandom_range(0, 9) != 0);
    end

    // Mid-line freeze for 37 clks.
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (f_h(ne) == 5 && f_v(ne) == 3) begin
        found = 1'b1;
        break;
      end
    end
    check("wait_freeze_point", int'(found), 1);
    enable = 1'b0;
    repeat (37) @(posedge clk);
    #1;
    enable = 1'b1;
    repeat (600) @(posedge clk);

    // Reset asserted mid-frame.
    #1;
    found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (f_h(ne) == 7 && f_v(ne) == 5) begin
        found = 1'b1;
        break;
      end
    end
    check("wait_reset_point", int'(found), 1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    data_mode = 1'b1;
    repeat (2 * HT * VT) @(posedge clk);
    #1;

    data_mode = 1'b0;
    repeat (2000) begin
      @(posedge clk);
      #1;
      enable = ($urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
